// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the dual-issue pairing controller: control-word bit
// positions, register-field helpers, slot record and FSM state encoding.
package issue_scheduler_pkg;

  localparam int CTRL_W      = 8;
  localparam int REG_WRITE   = 0;
  localparam int USES_RS1    = 1;
  localparam int USES_RS2    = 2;
  localparam int MEM_READ    = 3;
  localparam int MEM_WRITE   = 4;
  localparam int COND_BRANCH = 5;
  localparam int JAL         = 6;
  localparam int JALR        = 7;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    logic [31:0] inst;
    ctrl_t       ctrl;
    logic [31:0] pc;
  } slot_t;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  function automatic logic [4:0] rd_f(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1_f(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_f(input logic [31:0] inst);
    return inst[24:20];
  endfunction

  function automatic logic is_mem(input ctrl_t c);
    return c[MEM_READ] | c[MEM_WRITE];
  endfunction

  function automatic logic is_cf(input ctrl_t c);
    return c[COND_BRANCH] | c[JAL] | c[JALR];
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-pair input, issue-lane output and control signals of the scheduler.
interface issue_scheduler_if
  import issue_scheduler_pkg::*;
#(
  parameter int COUNT_W = 32
);
  logic               valid_i;
  logic [31:0]        inst0_i, inst1_i;
  ctrl_t              ctrl0_i, ctrl1_i;
  logic [31:0]        pc_0_i, pc_1_i;
  logic               flush_i;
  logic               ex_ready_i;
  logic               issue0_valid_o, issue1_valid_o;
  logic [31:0]        issue0_inst_o, issue1_inst_o;
  ctrl_t              issue0_ctrl_o, issue1_ctrl_o;
  logic [31:0]        issue0_pc_o, issue1_pc_o;
  logic               stall_o;
  logic [COUNT_W-1:0] split_count_o;

  modport master (
    output valid_i, inst0_i, inst1_i, ctrl0_i, ctrl1_i, pc_0_i, pc_1_i,
           flush_i, ex_ready_i,
    input  issue0_valid_o, issue1_valid_o, issue0_inst_o, issue1_inst_o,
           issue0_ctrl_o, issue1_ctrl_o, issue0_pc_o, issue1_pc_o,
           stall_o, split_count_o
  );

  modport slave (
    input  valid_i, inst0_i, inst1_i, ctrl0_i, ctrl1_i, pc_0_i, pc_1_i,
           flush_i, ex_ready_i,
    output issue0_valid_o, issue1_valid_o, issue0_inst_o, issue1_inst_o,
           issue0_ctrl_o, issue1_ctrl_o, issue0_pc_o, issue1_pc_o,
           stall_o, split_count_o
  );
endinterface

// File: rtl/issue_scheduler_pair_hazard.sv
// Intra-pair hazard detect: RAW on slot 0's destination, structural memory
// and control-flow collisions. WAW is allowed since lane 1 wins at writeback.
module issue_scheduler_pair_hazard
  import issue_scheduler_pkg::*;
#(
  parameter bit ALLOW_DUAL_MEM = 1'b0
) (
  input  logic [31:0] inst0_i,
  input  logic [31:0] inst1_i,
  input  ctrl_t       ctrl0_i,
  input  ctrl_t       ctrl1_i,
  output logic        conflict_o
);
  logic [4:0] rd0;
  logic       raw, mem, cf;

  assign rd0 = rd_f(inst0_i);

  assign raw = ctrl0_i[REG_WRITE] && (rd0 != 5'd0) &&
               ((ctrl1_i[USES_RS1] && (rs1_f(inst1_i) == rd0)) ||
                (ctrl1_i[USES_RS2] && (rs2_f(inst1_i) == rd0)));
  assign mem = !ALLOW_DUAL_MEM && is_mem(ctrl0_i) && is_mem(ctrl1_i);
  assign cf  = is_cf(ctrl0_i) && is_cf(ctrl1_i);

  assign conflict_o = raw | mem | cf;
endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue pairing controller: owns the issue registers, splits conflicting
// pairs over two cycles by holding slot 1 and stalling the front end.
//
// state    | meaning
// ST_PAIR  | accept a decode pair; issue both or split on conflict
// ST_SPLIT | issue the held slot 1 alone; front end held by stall_o
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter bit ALLOW_DUAL_MEM = 1'b0,
  parameter int COUNT_W        = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  issue_scheduler_if.slave bus
);
  state_e             state_q, state_d;
  slot_t              lane0_q, lane0_d, lane1_q, lane1_d, hold_q, hold_d;
  logic               v0_q, v0_d, v1_q, v1_d, hold_v_q, hold_v_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               conflict;
  slot_t              slot0, slot1;

  assign slot0 = '{inst: bus.inst0_i, ctrl: bus.ctrl0_i, pc: bus.pc_0_i};
  assign slot1 = '{inst: bus.inst1_i, ctrl: bus.ctrl1_i, pc: bus.pc_1_i};

  issue_scheduler_pair_hazard #(.ALLOW_DUAL_MEM(ALLOW_DUAL_MEM)) u_hazard (
    .inst0_i    (bus.inst0_i),
    .inst1_i    (bus.inst1_i),
    .ctrl0_i    (bus.ctrl0_i),
    .ctrl1_i    (bus.ctrl1_i),
    .conflict_o (conflict)
  );

  always_comb begin
    state_d  = state_q;
    lane0_d  = lane0_q;
    lane1_d  = lane1_q;
    hold_d   = hold_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    hold_v_d = hold_v_q;
    cnt_d    = cnt_q;
    if (bus.flush_i) begin
      v0_d     = 1'b0;
      v1_d     = 1'b0;
      hold_v_d = 1'b0;
      state_d  = ST_PAIR;
    end else if (bus.ex_ready_i) begin
      case (state_q)
        ST_PAIR: begin
          if (!bus.valid_i) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
          end else if (!conflict) begin
            lane0_d = slot0;
            lane1_d = slot1;
            v0_d    = 1'b1;
            v1_d    = 1'b1;
          end else begin
            lane0_d  = slot0;
            v0_d     = 1'b1;
            v1_d     = 1'b0;
            hold_d   = slot1;
            hold_v_d = 1'b1;
            state_d  = ST_SPLIT;
            cnt_d    = cnt_q + COUNT_W'(1);
          end
        end
        ST_SPLIT: begin
          lane0_d  = hold_q;
          v0_d     = hold_v_q;
          v1_d     = 1'b0;
          hold_v_d = 1'b0;
          state_d  = ST_PAIR;
        end
        default: state_d = ST_PAIR;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_PAIR;
      lane0_q  <= '0;
      lane1_q  <= '0;
      hold_q   <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane0_q  <= lane0_d;
      lane1_q  <= lane1_d;
      hold_q   <= hold_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall_o        = !bus.ex_ready_i || (state_q == ST_SPLIT);
  assign bus.issue0_valid_o = v0_q;
  assign bus.issue1_valid_o = v1_q;
  assign bus.issue0_inst_o  = lane0_q.inst;
  assign bus.issue1_inst_o  = lane1_q.inst;
  assign bus.issue0_ctrl_o  = lane0_q.ctrl;
  assign bus.issue1_ctrl_o  = lane1_q.ctrl;
  assign bus.issue0_pc_o    = lane0_q.pc;
  assign bus.issue1_pc_o    = lane1_q.pc;
  assign bus.split_count_o  = cnt_q;
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
Dual-issue pairing controller that sits between the two-slot decode stage and the issue/execute registers. It takes a decoded instruction pair and checks intra-pair hazards. It either issues both instructions in one cycle, or splits the pair over two cycles by holding slot 1 and stalling the front end. It also owns the issue-stage pipeline registers and flushes them on redirect.

Parameters:
ALLOW_DUAL_MEM, 0, 1 = two memory ops may pair (dual-ported LSU); 0 = memory ops in both slots force a split.
COUNT_W, 32, width of the split performance counter.

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  decode pair valid
inst0_i / inst1_i  in  32  raw instructions, slot 0 older
ctrl0_i / ctrl1_i  in  `CTRL_BUS  decoded control words
pc_0_i / pc_1_i  in  32  slot PCs
flush_i  in  1  redirect (decode not-a-branch fix, or execute mispredict)
ex_ready_i  in  1  downstream accepts issue registers this cycle
issue0_valid_o / issue1_valid_o  out  1  lane valids
issue0_inst_o / issue1_inst_o  out  32
issue0_ctrl_o / issue1_ctrl_o  out  `CTRL_BUS
issue0_pc_o / issue1_pc_o  out  32
stall_o  out  1  hold fetch/decode pair
split_count_o  out  COUNT_W  number of splits since reset

Behaviour:
- Reset (rst_i high at posedge):
  - issue*_valid_o = 0; issue data registers = 0.
  - State = PAIR, hold register invalid, split_count_o = 0.
- Register fields: rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20].
- Conflict (combinational, from slot inputs). Conflict is true if any of:
  - RAW: ctrl0 REG_WRITE && rd0 != 0 && ((USES_RS1_1 && rs1_1 == rd0) || (USES_RS2_1 && rs2_1 == rd0)).
  - MEM: !ALLOW_DUAL_MEM && both slots have MEM_READ or MEM_WRITE.
  - CF: both slots have COND_BRANCH, JAL or JALR (single branch unit).
  - WAW (same rd in both slots) is not a conflict; lane 1 wins at writeback.
- stall_o = !ex_ready_i || (state == SPLIT). Combinational; no valid gating.
- Priority each cycle: rst_i > flush_i > !ex_ready_i > state action.
- flush_i:
  - Clears both issue valids, invalidates the hold register, state = PAIR.
  - split_count_o is unchanged; flush wins over a simultaneous conflict.
- !ex_ready_i: all issue registers and state hold their values.
- PAIR state, ex_ready_i high:
  - valid_i = 0: both valids -> 0 (bubble).
  - valid_i && !conflict: lane0 <- slot0, lane1 <- slot1, both valid.
  - valid_i && conflict:
    - lane0 <- slot0 valid; lane1 invalid.
    - Hold register <- slot1 (inst, ctrl, pc).
    - State -> SPLIT; split_count_o += 1, wrapping at 2^COUNT_W.
- SPLIT state, ex_ready_i high:
  - lane0 <- hold register valid; lane1 invalid; state -> PAIR.
  - The front-end pair held by stall_o is not consumed this cycle.
- Latency: one cycle from acceptance to issue register output.
- Issue order is always preserved: lane0 older than lane1, held slot1 never issues before slot0.
- Reset or flush mid-SPLIT: held instruction is dropped, never issued.

Decomposition:
- src/defs.v holds the following:
  - Control bit indices: REG_WRITE, USES_RS1, USES_RS2, MEM_READ, MEM_WRITE, COND_BRANCH, JAL, JALR, and `CTRL_BUS.
  - Register field slice macros (RD, RS1, RS2).
  - The PAIR/SPLIT state encodings.
- One combinational sub-module, pair_hazard: inputs inst0/inst1/ctrl0/ctrl1 plus ALLOW_DUAL_MEM; output conflict.
- issue_scheduler holds the FSM, hold register, issue registers and counter.

Test Plan:
- Independent pair, 0x00100293 (addi x5,x0,1) + 0x00200313 (addi x6,x0,2), ex_ready_i=1 -> next cycle both valids=1, stall_o=0, split_count_o=0.
- RAW pair, 0x00100293 + 0x00228313 (addi x6,x5,2):
  - Cycle+1: lane0 = 0x00100293 only, stall_o=1.
  - Cycle+2: lane0 = 0x00228313, lane1 invalid, stall_o=0, split_count_o=1.
- x0 writer, 0x00000013 (nop) + 0x00000313 (addi x6,x0,0) -> no split, both issue.
- Dual loads 0x00012083 (lw x1,0(x2)) + 0x00412183 (lw x3,4(x2)):
  - ALLOW_DUAL_MEM=0 -> split, count+1.
  - ALLOW_DUAL_MEM=1 -> paired.
- Flush in SPLIT: after RAW split, assert flush_i -> next cycle both valids 0, state PAIR, stall_o=0, held 0x00228313 never appears on any lane.
- Backpressure: ex_ready_i=0 for 3 cycles with a valid pair -> stall_o=1, issue registers unchanged; ex_ready_i=1 -> pair issues exactly once.
